// File: rtl/mul_mdc_tcdm_mux_pkg.sv
// Shared constants and types for the mul_mdc TCDM concentrator.
package mul_mdc_package;

    localparam int unsigned MUX_MAX_OUTSTANDING = 4;
    localparam int unsigned MUX_MP              = 4;

    typedef logic [$clog2(MUX_MP)-1:0] port_id_t;

endpackage

// File: rtl/mul_mdc_id_fifo.sv
// Synchronous FIFO holding the port IDs of granted, not yet answered requests.
module mul_mdc_id_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mul_mdc_tcdm_mux.sv
// Round-robin concentrator of MP TCDM master ports onto one slave port with in-order response steering.
module mul_mdc_tcdm_mux
    import mul_mdc_package::*;
#(
    parameter int unsigned MP              = MUX_MP,
    parameter int unsigned MAX_OUTSTANDING = MUX_MAX_OUTSTANDING,
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [MP-1:0]              in_req,
    output logic [MP-1:0]              in_gnt,
    input  logic [MP-1:0][AW-1:0]      in_add,
    input  logic [MP-1:0]              in_wen,
    input  logic [MP-1:0][DW/8-1:0]    in_be,
    input  logic [MP-1:0][DW-1:0]      in_data,
    output logic [MP-1:0][DW-1:0]      in_r_data,
    output logic [MP-1:0]              in_r_valid,
    output logic                       out_req,
    input  logic                       out_gnt,
    output logic [AW-1:0]              out_add,
    output logic                       out_wen,
    output logic [DW/8-1:0]            out_be,
    output logic [DW-1:0]              out_data,
    input  logic [DW-1:0]              out_r_data,
    input  logic                       out_r_valid,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int unsigned IDW = $clog2(MP);
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING) + 1;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] head;
    logic           found;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [CW-1:0]  count;

    always_comb begin
        int unsigned   idx;
        logic [IDW-1:0] cand;
        idx    = 0;
        cand   = '0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < MP; i++) begin
            idx  = (32'(rr_ptr) + i) % MP;
            cand = IDW'(idx);
            if (!found && in_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // full comes from the registered count, so a same-cycle pop cannot re-open the request path.
    assign out_req = found & ~full;
    assign push    = out_req & out_gnt;
    assign pop     = out_r_valid & ~empty;
    assign busy_o  = (count != '0);

    always_comb begin
        out_add    = '0;
        out_wen    = 1'b0;
        out_be     = '0;
        out_data   = '0;
        in_gnt     = '0;
        in_r_valid = '0;
        in_r_data  = '0;
        if (out_req) begin
            out_add        = in_add[winner];
            out_wen        = in_wen[winner];
            out_be         = in_be[winner];
            out_data       = in_data[winner];
            in_gnt[winner] = out_gnt;
        end
        if (pop) begin
            in_r_valid[head] = 1'b1;
            in_r_data[head]  = out_r_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr <= (winner == IDW'(MP - 1)) ? '0 : winner + 1'b1;
            end
            if (out_r_valid && empty) begin
                err_o <= 1'b1;
            end
        end
    end

    mul_mdc_id_fifo #(
        .W     (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (winner),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: doc/mul_mdc_tcdm_mux.md
Name: mul_mdc_tcdm_mux

Overview:
- Downstream neighbour of the mul_mdc top-level wrapper.
- Concentrates its MP TCDM master ports (req/gnt/add/wen/be/data, r_data/r_valid) onto a single TCDM slave port, e.g. one memory bank or one interconnect port.
- Uses round-robin arbitration and steers in-order responses back to the issuing port through an outstanding-ID FIFO.

Parameters:
- MP, 4, number of upstream TCDM master ports (>=2).
- MAX_OUTSTANDING, 4, depth of the outstanding-ID FIFO (power of 2, >=2).
- DW, 32, data width.
- AW, 32, address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- in_req  in  MP  per-port request
- in_gnt  out  MP  per-port grant
- in_add  in  MPxAW  per-port address
- in_wen  in  MP  per-port write-enable (1 = read, TCDM convention)
- in_be  in  MPx(DW/8)  per-port byte enable
- in_data  in  MPxDW  per-port write data
- in_r_data  out  MPxDW  per-port read data
- in_r_valid  out  MP  per-port response valid
- out_req  out  1  slave request
- out_gnt  in  1  slave grant
- out_add  out  AW  slave address
- out_wen  out  1  slave write-enable
- out_be  out  DW/8  slave byte enable
- out_data  out  DW  slave write data
- out_r_data  in  DW  slave read data
- out_r_valid  in  1  slave response valid (one per granted request, reads and writes)
- busy_o  out  1  outstanding count != 0
- err_o  out  1  sticky: out_r_valid seen with empty FIFO

Behaviour:
- Clocking and reset: single clock, all state on rising clk_i. When rst_i=1 at an edge:
  - rr_ptr=0, FIFO empty, count=0, err_o=0.
  - Combinational outputs follow from the reset state: out_req=0, in_gnt=0, in_r_valid=0, busy_o=0.
- Reset mid-operation: in-flight transactions are discarded. Responses arriving after reset hit the empty FIFO and set err_o.
- Arbitration (combinational):
  - Among ports with in_req=1, pick the first at or after rr_ptr, cyclically.
  - out_req=1 iff some in_req=1 AND count<MAX_OUTSTANDING.
  - out_add/wen/be/data are muxed from the winner. When out_req=0 they are 0.
  - in_gnt[winner] = out_gnt & out_req. All other in_gnt bits are 0.
  - Only one in_gnt bit is ever high.
- Grant event (out_req & out_gnt):
  - Push the winner index into the FIFO.
  - rr_ptr <= (winner+1) mod MP.
  - No grant means rr_ptr is held.
  - Upstream must hold req and payload stable until granted. The block does not register payload; request-path latency is 0 cycles.
- Full: when count==MAX_OUTSTANDING, out_req=0 and all in_gnt=0.
  - A push is never accepted on the same cycle as a pop when full, so there is no r_valid→req combinational path.
- Response (out_r_valid=1, FIFO not empty):
  - in_r_valid[head]=1 and in_r_data[head]=out_r_data, combinationally (0 cycles).
  - Pop the head.
  - in_r_data for non-head ports = 0.
- Response with FIFO empty: dropped, err_o<=1 (sticky until reset).
- Simultaneous push and pop (not full): count unchanged, pointers both advance.
- Pointer wrap: read and write pointers wrap mod MAX_OUTSTANDING. count is (log2(MAX_OUTSTANDING)+1) bits wide.
- Responses are strictly in grant order; the slave must return in order.
- busy_o = (count!=0), combinational from the register.

Decomposition:
- mul_mdc_package:
  - MUX_MAX_OUTSTANDING default constant.
  - typedef port_id_t = logic [$clog2(MP)-1:0].
- Sub-module mul_mdc_id_fifo: synchronous FIFO with push/pop/full/empty/count and head output. This holds the outstanding-ID store.
- The arbiter stays inline in the top module.

Test Plan:
- Single read: port 2 req, add=0x1000, wen=1, out_gnt=1; slave returns r_valid next cycle with data 0xDEADBEEF → in_gnt=4'b0100 for 1 cycle, then in_r_valid=4'b0100 with in_r_data[2]=0xDEADBEEF, busy_o returns to 0.
- Fairness: all 4 ports request continuously, out_gnt=1 each cycle → grant order 0,1,2,3,0,…. Each port gets exactly 2 grants in 8 cycles. Responses are routed in the same order.
- Full: out_gnt=1, no r_valid for 4 cycles, then all 4 ports request → 4 grants, then out_req=0 and in_gnt=0. A single r_valid frees one slot; the next grant appears the cycle after the pop, never the same cycle.
- Simultaneous push/pop: with count=2, grant port 1 and return a response for the head port 3 in the same cycle → count stays 2, in_r_valid[3]=1, and FIFO order is preserved after pointer wrap, checked over 10 transactions.
- Stray response: after reset, assert out_r_valid with data 0x5 → all in_r_valid=0, err_o=1 from the next cycle, held until rst_i.
- Reset mid-flight: 3 outstanding, rst_i=1 for one cycle → busy_o=0, FIFO empty. The next request from port 0 is granted, and a subsequent response is routed to port 0.
